// File: rtl/tt_um_bitserial_adder_if.sv
// ---------------------------------------------------------------------------
// tt_um_bitserial_adder_if
//
// Groups the TinyTapeout tile pins (apart from clock and reset) of the
// bit-serial adder into a single bundle.
//
//   ena      : design enable; when low the tile holds all state
//   ui_in    : operand byte, bits [WIDTH-1:0] used
//   uo_out   : sum[WIDTH-1:0], upper bits zero
//   uio_in   : [3]=load_a, [4]=load_b, [5]=start
//   uio_out  : [0]=cout, [1]=busy, [2]=done, [7:3] zero
//   uio_oe   : constant 8'b0000_0111
//
// The slave modport is taken by the tile. The master modport is taken by
// whatever drives it: the harness or a bench.
// ---------------------------------------------------------------------------
interface tt_um_bitserial_adder_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );
endinterface

// File: rtl/tt_um_bitserial_adder.sv
// ---------------------------------------------------------------------------
// tt_um_bitserial_adder
//
// Bit-serial WIDTH-bit adder tile.
//
// Operands A and B are loaded in parallel from ui_in. A start pulse then
// shifts them LSB-first through a full-adder slice, built from two
// half-adder cells plus a carry flop. Each sum bit enters the top of a
// result shift register. After WIDTH shifts the result register holds the
// sum, LSB at bit 0, and the tile enters DONE.
//
// Ports:
//   clk      : system clock, all state updates on the rising edge
//   rst_n    : asynchronous active-low reset, clears all state
//   io.ena   : enable; when low every register holds
//   io.ui_in : operand byte for load_a / load_b
//   io.uio_in: [3]=load_a, [4]=load_b, [5]=start
//   io.uo_out: result register (the partial sum while busy)
//   io.uio_out: [0]=cout, [1]=busy, [2]=done
//   io.uio_oe : constant 8'b0000_0111
//
// WIDTH is legal from 2 to 8.
// ---------------------------------------------------------------------------
module tt_um_bitserial_adder #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tt_um_bitserial_adder_if.slave  io
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  result;
    logic              carry;
    logic              cout;
    logic [CNT_W-1:0]  bit_cnt;

    logic              load_a;
    logic              load_b;
    logic              start;
    logic              accept;
    logic              last_bit;
    logic [WIDTH-1:0]  a_ld;
    logic [WIDTH-1:0]  b_ld;
    logic              sum_bit;
    logic              carry_bit;

    // Pins without a function are reduced into a single sink. This keeps
    // them visibly accounted for.
    logic              unused_pins;

    // -----------------------------------------------------------------------
    // Half-adder cell: {carry, sum}
    // -----------------------------------------------------------------------
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full adder from two half-adder cells. The two cell carries can never
    // both be 1, so an OR merges them.
    function automatic logic [1:0] full_add(input logic x, input logic y,
                                            input logic cin);
        logic [1:0] h0;
        logic [1:0] h1;
        h0 = half_add(x, y);
        h1 = half_add(h0[0], cin);
        return {h0[1] | h1[1], h1[0]};
    endfunction

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    assign load_a   = io.uio_in[3];
    assign load_b   = io.uio_in[4];
    assign start    = io.uio_in[5];

    // Loads and start are accepted only when not running.
    assign accept   = (state != RUN);
    assign last_bit = (bit_cnt == LAST_BIT);

    // Operand values that a start should use. A load in the same cycle as
    // start wins, so the new operation sees the freshly loaded byte.
    assign a_ld = load_a ? io.ui_in[WIDTH-1:0] : op_a;
    assign b_ld = load_b ? io.ui_in[WIDTH-1:0] : op_b;

    assign {carry_bit, sum_bit} = full_add(op_a[0], op_b[0], carry);

    assign unused_pins = &{1'b0, io.ui_in, io.uio_in[7:6], io.uio_in[2:0]};

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (io.ena) begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // A start held over from the previous run restarts
                // immediately.
                if (start) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand, carry, counter and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            result  <= '0;
            carry   <= 1'b0;
            cout    <= 1'b0;
            bit_cnt <= '0;
        end else if (io.ena) begin
            if (accept) begin
                op_a <= a_ld;
                op_b <= b_ld;
                if (start) begin
                    carry   <= 1'b0;
                    cout    <= 1'b0;
                    bit_cnt <= '0;
                    result  <= '0;
                end
            end else begin
                // One bit per clock, LSB first. Each sum bit enters at the
                // top of the result register and moves down, so after WIDTH
                // shifts bit 0 holds the first sum bit.
                op_a    <= op_a >> 1;
                op_b    <= op_b >> 1;
                carry   <= carry_bit;
                result  <= {sum_bit, result[WIDTH-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
                if (last_bit) begin
                    cout <= carry_bit;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pin mapping
    // -----------------------------------------------------------------------
    always_comb begin
        io.uo_out              = '0;
        io.uo_out[WIDTH-1:0]   = result;
        io.uio_out             = '0;
        io.uio_out[0]          = cout;
        io.uio_out[1]          = (state == RUN);
        io.uio_out[2]          = (state == DONE);
    end

    assign io.uio_oe = 8'b0000_0111;

endmodule

// File: tb/tb_tt_um_bitserial_adder.sv
// ---------------------------------------------------------------------------
// tb_tt_um_bitserial_adder
//
// Directed bench for the bit-serial adder. The stimulus process issues
// operations and pushes each expected {sum, cout} into a queue. A separate
// monitor pops one entry each time done rises and compares it with the pins.
// ---------------------------------------------------------------------------
module tb_tt_um_bitserial_adder;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    tt_um_bitserial_adder_if io ();

    tt_um_bitserial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    int checks = 0;
    int errors = 0;

    // expected {uo_out, cout}
    logic [8:0] sb[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Load A, load B, then pulse start. The start edge is edge k. The task
    // returns at the negedge just after edge k, with all controls released.
    task automatic begin_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        io.ui_in  = a;
        io.uio_in = 8'h08;
        @(negedge clk);
        io.ui_in  = b;
        io.uio_in = 8'h10;
        @(negedge clk);
        io.uio_in = 8'h20;
        @(negedge clk);
        io.uio_in = 8'h00;
        check("busy_after_start", 32'(io.uio_out[1]), 32'd1);
        check("done_after_start", 32'(io.uio_out[2]), 32'd0);
    endtask

    // Called at negedge j=0 (just after the start edge). Walks negedges
    // until done, optionally injecting uio_in/ui_in at one step and holding
    // ena low for a span of steps. Returns the step count at which done
    // was seen, or -1 if the bound expired.
    task automatic run_wait(input int act_at, input logic [7:0] act_ui,
                            input logic [7:0] act_uio, input int gap_at,
                            input int gap_len, output int lat);
        lat = -1;
        for (int j = 0; j < 60; j++) begin
            if (io.uio_out[2]) begin
                lat = j;
                break;
            end
            if (gap_len > 0 && j == gap_at + gap_len - 1) begin
                check("busy_while_disabled", 32'(io.uio_out[1]), 32'd1);
            end
            if (j == act_at) begin
                io.ui_in  = act_ui;
                io.uio_in = act_uio;
            end else begin
                io.uio_in = 8'h00;
            end
            io.ena = !(j >= gap_at && j < gap_at + gap_len);
            @(negedge clk);
        end
        io.ena    = 1'b1;
        io.uio_in = 8'h00;
    endtask

    task automatic simple_op(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] sum, input logic co);
        int lat;
        begin_op(a, b);
        sb.push_back({sum, co});
        run_wait(-1, 8'h00, 8'h00, -1, 0, lat);
        check("latency", 32'(lat), 32'(WIDTH));
    endtask

    // ------------------------------------------------------------------
    // Monitor: compare on every rising edge of done
    // ------------------------------------------------------------------
    initial begin
        logic       prev_done;
        logic [8:0] exp;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && io.uio_out[2] === 1'b1 && !prev_done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got uo_out=%0h cout=%0b expected no completion",
                             io.uo_out, io.uio_out[0]);
                end else begin
                    exp = sb.pop_front();
                    if ({io.uo_out, io.uio_out[0]} !== exp) begin
                        errors++;
                        $display("FAIL result: got uo_out=%0h cout=%0b expected uo_out=%0h cout=%0b",
                                 io.uo_out, io.uio_out[0], exp[8:1], exp[0]);
                    end
                end
            end
            prev_done = (io.uio_out[2] === 1'b1);
        end
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int lat;
        rst_n     = 1'b0;
        io.ena    = 1'b1;
        io.ui_in  = 8'h00;
        io.uio_in = 8'h00;

        repeat (2) @(negedge clk);
        check("reset_uo_out", 32'(io.uo_out), 32'h00);
        check("reset_uio_out", 32'(io.uio_out), 32'h00);
        check("reset_uio_oe", 32'(io.uio_oe), 32'h07);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_uio_out", 32'(io.uio_out), 32'h00);

        // basic sums and carry boundary
        simple_op(8'h03, 8'h05, 8'h08, 1'b0);
        simple_op(8'hFF, 8'h01, 8'h00, 1'b1);
        simple_op(8'hAA, 8'h55, 8'hFF, 1'b0);
        simple_op(8'hFF, 8'hFF, 8'hFE, 1'b1);

        // DONE holds its outputs
        repeat (3) @(negedge clk);
        check("done_hold_uo_out", 32'(io.uo_out), 32'hFE);
        check("done_hold_flags", 32'(io.uio_out), 32'h05);

        // load_a and start during RUN (sampled at edge k+3) are ignored
        begin_op(8'h12, 8'h34);
        sb.push_back({8'h46, 1'b0});
        run_wait(2, 8'h77, 8'h28, -1, 0, lat);
        check("latency_ignored_start", 32'(lat), 32'(WIDTH));

        // async reset mid-run clears everything at once
        begin_op(8'h10, 8'h20);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_uo_out", 32'(io.uo_out), 32'h00);
        check("midrun_reset_uio_out", 32'(io.uio_out), 32'h00);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_uio_out", 32'(io.uio_out), 32'h00);
        simple_op(8'h01, 8'h01, 8'h02, 1'b0);

        // ena low for 5 edges mid-run delays completion by 5
        begin_op(8'h0F, 8'h01);
        sb.push_back({8'h10, 1'b0});
        run_wait(-1, 8'h00, 8'h00, 2, 5, lat);
        check("latency_with_ena_gap", 32'(lat), 32'(WIDTH + 5));

        // load both and start together from DONE
        @(negedge clk);
        io.ui_in  = 8'h80;
        io.uio_in = 8'h38;
        @(negedge clk);
        io.uio_in = 8'h00;
        check("restart_done_cleared", 32'(io.uio_out[2]), 32'd0);
        check("restart_busy", 32'(io.uio_out[1]), 32'd1);
        sb.push_back({8'h00, 1'b1});
        run_wait(-1, 8'h00, 8'h00, -1, 0, lat);
        check("latency_restart", 32'(lat), 32'(WIDTH));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
